bin2bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.

---
 rtl/bin2bcd_seq.sv | 106 ++++++++++
 tb/tb_bin2bcd_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Results saturate to all nines when the value needs more than DIGITS digits.
module bin2bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   nines;
  logic               last_shift;
  logic               load;

  // Per-digit add-3 correction; digits never carry into each other.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign adj[4*gi +: 4]   = (work_q[4*gi +: 4] >= 4'd5) ? work_q[4*gi +: 4] + 4'd3
                                                          : work_q[4*gi +: 4];
    assign nines[4*gi +: 4] = 4'd9;
  end

  assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));
  assign load       = start && (state_q != SHIFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d   = bin;
      work_d    = '0;
      cnt_d     = '0;
      ovf_acc_d = 1'b0;
    end else if (state_q == SHIFT) begin
      // A 1 leaving the top digit means the value exceeds DIGITS decimal digits.
      work_d    = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
      shift_d   = {shift_q[BIN_W-2:0], 1'b0};
      ovf_acc_d = ovf_acc_q | adj[BCD_W-1];
      cnt_d     = cnt_q + CNT_W'(1);
      if (last_shift) begin
        bcd_d = ovf_acc_d ? nines : work_d;
        ovf_d = ovf_acc_d;
      end
    end
  end

  always_comb begin
    busy     = (state_q == SHIFT);
    done     = (state_q == DONE);
    bcd      = bcd_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a default 4-digit instance and a 2-digit
// instance for saturation; expected values are hand-computed or derived by /,%.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_a, start_b;
  logic [9:0]  bin_a, bin_b;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [15:0] bcd_a;
  logic [7:0]  bcd_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bin2bcd_seq dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
  );

  bin2bcd_seq #(.BIN_W(10), .DIGITS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
  );

  // Stimulus only: pulse start with v, return cycles until done (-1 on timeout).
  task automatic run_a(input logic [9:0] v, output int lat);
    @(negedge clk);
    bin_a   = v;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_a) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy_a, done_a, ovf_a, bcd_a} !== 19'd0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b ovf=%b bcd=%h want all 0",
               busy_a, done_a, ovf_a, bcd_a);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy_a, done_a, ovf_a, bcd_a} !== 19'd0) begin
      bad++;
      $display("FAIL idle_hold: got busy=%b done=%b ovf=%b bcd=%h want all 0",
               busy_a, done_a, ovf_a, bcd_a);
    end
    $display("reset: busy=%b done=%b bcd=%h", busy_a, done_a, bcd_a);
  endtask

  task automatic test_values();
    logic [9:0]  vin [6] = '{10'd0, 10'd1023, 10'd509, 10'd42, 10'd999, 10'd1000};
    logic [15:0] vexp[6] = '{16'h0000, 16'h1023, 16'h0509, 16'h0042, 16'h0999, 16'h1000};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_a(vin[i], lat);
      total++;
      if (lat != 10) begin
        bad++;
        $display("FAIL latency_%0d: got %0d want 10", vin[i], lat);
      end
      total++;
      if (bcd_a !== vexp[i] || ovf_a !== 1'b0) begin
        bad++;
        $display("FAIL value_%0d: got bcd=%h ovf=%b want bcd=%h ovf=0",
                 vin[i], bcd_a, ovf_a, vexp[i]);
      end
      @(negedge clk);
      total++;
      if (done_a !== 1'b0 || bcd_a !== vexp[i]) begin
        bad++;
        $display("FAIL pulse_%0d: got done=%b bcd=%h want done=0 bcd=%h",
                 vin[i], done_a, bcd_a, vexp[i]);
      end
      $display("convert %0d: bcd=%h ovf=%b lat=%0d", vin[i], bcd_a, ovf_a, lat);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] vin [3] = '{10'd100, 10'd42, 10'd99};
    logic [7:0] vexp[3] = '{8'h99, 8'h42, 8'h99};
    logic       oexp[3] = '{1'b1, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bin_b = vin[i]; start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (done_b) begin
          lat = k;
          break;
        end
      end
      total++;
      if (lat != 10 || bcd_b !== vexp[i] || ovf_b !== oexp[i]) begin
        bad++;
        $display("FAIL ovf2_%0d: got bcd=%h ovf=%b lat=%0d want bcd=%h ovf=%b lat=10",
                 vin[i], bcd_b, ovf_b, lat, vexp[i], oexp[i]);
      end
      $display("2-digit %0d: bcd=%h ovf=%b", vin[i], bcd_b, ovf_b);
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    logic busy_ok = 1'b1;
    @(negedge clk);
    bin_a = 10'd300; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_a) begin
        lat = k;
        break;
      end
      if (busy_a !== 1'b1) busy_ok = 1'b0;
      if (k == 3 || k == 6) begin
        bin_a = 10'd7; start_a = 1'b1;
      end else begin
        start_a = 1'b0;
      end
    end
    start_a = 1'b0;
    total++;
    if (lat != 10 || bcd_a !== 16'h0300 || !busy_ok) begin
      bad++;
      $display("FAIL ignore_start: got bcd=%h lat=%0d busy_ok=%b want bcd=0300 lat=10 busy_ok=1",
               bcd_a, lat, busy_ok);
    end
    @(negedge clk);
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL ignore_after: got busy=%b done=%b want 0 0", busy_a, done_a);
    end
    $display("ignore start: bcd=%h lat=%0d", bcd_a, lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    @(negedge clk);
    bin_a = 10'd777; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || bcd_a !== 16'h0000 || ovf_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b done=%b bcd=%h ovf=%b want 0 0 0000 0",
               busy_a, done_a, bcd_a, ovf_a);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_a || busy_a) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", seen);
    end
    run_a(10'd777, lat);
    total++;
    if (lat != 10 || bcd_a !== 16'h0777) begin
      bad++;
      $display("FAIL after_abort: got bcd=%h lat=%0d want 0777 lat=10", bcd_a, lat);
    end
    $display("reset mid: rerun bcd=%h lat=%0d", bcd_a, lat);
  endtask

  task automatic test_back_to_back();
    logic [15:0] vexp[3] = '{16'h0001, 16'h0002, 16'h0003};
    int want[3] = '{10, 11, 11};
    int lat;
    @(negedge clk);
    bin_a = 10'd1; start_a = 1'b1;
    @(negedge clk);
    bin_a = 10'd2;
    for (int i = 0; i < 3; i++) begin
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (done_a) begin
          lat = k;
          break;
        end
      end
      if (i == 2) start_a = 1'b0;
      total++;
      if (lat != want[i] || bcd_a !== vexp[i]) begin
        bad++;
        $display("FAIL b2b_%0d: got bcd=%h lat=%0d want bcd=%h lat=%0d",
                 i, bcd_a, lat, vexp[i], want[i]);
      end
      $display("back-to-back %0d: bcd=%h lat=%0d", i, bcd_a, lat);
      if (i == 0) begin
        @(negedge clk);
        bin_a = 10'd3;
        want[1] = want[1] - 1;
      end
    end
    @(negedge clk);
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stop: got busy=%b done=%b want 0 0", busy_a, done_a);
    end
  endtask

  task automatic test_sweep();
    int errs = 0;
    int digit_errs = 0;
    int lat;
    logic [15:0] exp_bcd;
    for (int v = 0; v < 1024; v++) begin
      exp_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      @(negedge clk);
      bin_a = 10'(v); start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        for (int d = 0; d < 4; d++)
          if (bcd_a[4*d +: 4] > 4'd9) digit_errs++;
        if (done_a) begin
          lat = k;
          break;
        end
      end
      if (lat != 10 || bcd_a !== exp_bcd || ovf_a !== 1'b0) begin
        errs++;
        if (errs <= 5)
          $display("FAIL sweep_%0d: got bcd=%h ovf=%b lat=%0d want bcd=%h ovf=0 lat=10",
                   v, bcd_a, ovf_a, lat, exp_bcd);
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL sweep: got %0d wrong results want 0", errs);
    end
    total++;
    if (digit_errs != 0) begin
      bad++;
      $display("FAIL digit_range: got %0d digits above 9 want 0", digit_errs);
    end
    $display("sweep 0-1023: wrong=%0d bad_digits=%0d", errs, digit_errs);
  endtask

  initial begin
    test_reset();
    test_values();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
